// File: rtl/alu_pkg.sv
// Shared types for the accumulator ALU: opcodes, FSM states and iterative-unit modes.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'd0,
      OP_OR   = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_ADDI = 4'd4,
      OP_MOV  = 4'd5,
      OP_CMP  = 4'd7,
      OP_SHL  = 4'd8,
      OP_SHR  = 4'd9,
      OP_MUL  = 4'd10
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0] MODE_SHL = 2'd0;
   localparam logic [1:0] MODE_SHR = 2'd1;
   localparam logic [1:0] MODE_MUL = 2'd2;

   // Unsigned compare encoding: 10 equal, 01 greater, 00 less.
   function automatic logic [1:0] cmp_code(input logic eq, input logic gt);
      if (eq)
         return 2'b10;
      else if (gt)
         return 2'b01;
      else
         return 2'b00;
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Multi-cycle datapath: one-bit-per-step shifter and shift-add unsigned multiplier.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 step,
   input  logic [1:0]           mode,
   input  logic [W-1:0]         a,
   input  logic [W-1:0]         b,
   input  logic                 fill,
   input  logic [$clog2(W):0]   count_init,
   output logic [W-1:0]         nxt_lo,
   output logic [W-1:0]         nxt_hi,
   output logic                 nxt_cout,
   output logic                 last
);

   localparam int CW = $clog2(W) + 1;

   logic [W-1:0]  lo;
   logic [W-1:0]  hi;
   logic [W-1:0]  mcand;
   logic [1:0]    mode_r;
   logic          fill_r;
   logic [CW-1:0] cnt;
   logic [W:0]    sum;

   // For MUL, lo holds the remaining multiplier bits and receives product bits from hi.
   always_comb begin
      sum      = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
      nxt_lo   = lo;
      nxt_hi   = hi;
      nxt_cout = 1'b0;
      case (mode_r)
         MODE_SHL: begin
            nxt_lo   = {lo[W-2:0], fill_r};
            nxt_cout = lo[W-1];
         end
         MODE_SHR: begin
            nxt_lo   = {fill_r, lo[W-1:1]};
            nxt_cout = lo[0];
         end
         MODE_MUL: begin
            nxt_hi   = sum[W:1];
            nxt_lo   = {sum[0], lo[W-1:1]};
            nxt_cout = |sum[W:1];
         end
         default: ;
      endcase
   end

   // The step that brings the counter to zero is the final one.
   assign last = (cnt <= CW'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lo     <= '0;
         hi     <= '0;
         mcand  <= '0;
         mode_r <= MODE_SHL;
         fill_r <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         lo     <= (mode == MODE_MUL) ? b : a;
         hi     <= '0;
         mcand  <= a;
         mode_r <= mode;
         fill_r <= fill;
         cnt    <= count_init;
      end else if (step && (cnt != '0)) begin
         lo  <= nxt_lo;
         hi  <= nxt_hi;
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/accum_alu_seq.sv
// Sequential accumulator ALU: issue FSM, operand capture and result registers;
// shifts and multiplies are delegated to alu_iter_unit.
module accum_alu_seq
   import alu_pkg::*;
#(
   parameter int W     = 8,
   parameter int IMM_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [IMM_W-1:0] imm,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [W-1:0]     acc,
   output logic [W-1:0]     data_out,
   output logic             carry_out,
   output logic [1:0]       cmp_flag,
   output logic             zero,
   output logic             parity
);

   localparam int LW = $clog2(W);
   localparam int CW = LW + 1;

   state_t           state;
   op_t              op_r;
   logic [W-1:0]     a_r;
   logic [W-1:0]     b_r;
   logic [IMM_W-1:0] imm_r;
   logic             ci_r;

   logic [W-1:0]     imm_ext;
   logic [W:0]       add_sum;
   logic [W:0]       sub_diff;
   logic [W:0]       addi_sum;
   logic [CW-1:0]    shamt;
   logic [CW-1:0]    iter_cnt_init;
   logic [1:0]       iter_mode;
   logic             iter_op;
   logic             iter_load;
   logic             iter_step;
   logic             iter_last;
   logic [W-1:0]     it_lo;
   logic [W-1:0]     it_hi;
   logic             it_cout;

   always_comb begin
      imm_ext              = '0;
      imm_ext[IMM_W-1:0]   = imm_r;
   end

   assign add_sum  = {1'b0, a_r} + {1'b0, b_r}     + {{W{1'b0}}, ci_r};
   assign sub_diff = {1'b0, a_r} - {1'b0, b_r}     + {{W{1'b0}}, ci_r};
   assign addi_sum = {1'b0, a_r} + {1'b0, imm_ext} + {{W{1'b0}}, ci_r};
   assign shamt    = {1'b0, b_r[LW-1:0]};

   // A zero-length shift is finished in EXEC and never enters ITER.
   always_comb begin
      iter_op       = 1'b0;
      iter_mode     = MODE_SHL;
      iter_cnt_init = shamt;
      case (op_r)
         OP_SHL: iter_op = (shamt != '0);
         OP_SHR: begin
            iter_op   = (shamt != '0);
            iter_mode = MODE_SHR;
         end
         OP_MUL: begin
            iter_op       = 1'b1;
            iter_mode     = MODE_MUL;
            iter_cnt_init = CW'(W);
         end
         default: ;
      endcase
   end

   assign iter_load = (state == S_EXEC) && iter_op;
   assign iter_step = (state == S_ITER);

   alu_iter_unit #(.W(W)) u_iter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (iter_load),
      .step       (iter_step),
      .mode       (iter_mode),
      .a          (a_r),
      .b          (b_r),
      .fill       (ci_r),
      .count_init (iter_cnt_init),
      .nxt_lo     (it_lo),
      .nxt_hi     (it_hi),
      .nxt_cout   (it_cout),
      .last       (iter_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         acc       <= '0;
         data_out  <= '0;
         carry_out <= 1'b0;
         cmp_flag  <= 2'b00;
         op_r      <= OP_AND;
         a_r       <= '0;
         b_r       <= '0;
         imm_r     <= '0;
         ci_r      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_r  <= op_t'(op);
                  a_r   <= in_a;
                  b_r   <= in_b;
                  imm_r <= imm;
                  ci_r  <= carry_in;
                  busy  <= 1'b1;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (op_r)
                  OP_AND:  acc <= a_r & b_r;
                  OP_OR:   acc <= a_r | b_r;
                  OP_ADD:  {carry_out, acc} <= add_sum;
                  OP_SUB:  {carry_out, acc} <= sub_diff;
                  OP_ADDI: {carry_out, acc} <= addi_sum;
                  OP_MOV:  data_out <= a_r;
                  OP_CMP:  cmp_flag <= cmp_code(a_r == b_r, a_r > b_r);
                  OP_SHL, OP_SHR: begin
                     if (shamt == '0) begin
                        acc       <= a_r;
                        carry_out <= 1'b0;
                     end
                  end
                  default: ;
               endcase
               if (iter_op) begin
                  state <= S_ITER;
               end else begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_ITER: begin
               // Results are taken from the final step's next-state values.
               if (iter_last) begin
                  acc       <= it_lo;
                  carry_out <= it_cout;
                  if (op_r == OP_MUL)
                     data_out <= it_hi;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign zero   = ~|acc;
   assign parity = ^acc;

endmodule

// File: tb/tb_accum_alu_seq.sv
// Bench for accum_alu_seq: directed vectors, reset scenarios and random ops
// checked against an arithmetic reference model.
module tb_accum_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, carry_in, busy, done, carry_out, zero, parity;
   logic [3:0] op;
   logic [7:0] in_a, in_b, acc, data_out;
   logic [2:0] imm;
   logic [1:0] cmp_flag;

   logic        rst16_n, start16, ci16, busy16, done16, cout16, zero16, par16;
   logic [3:0]  op16, imm16;
   logic [15:0] a16, b16, acc16, dout16;
   logic [1:0]  cmp16;

   accum_alu_seq #(.W(8), .IMM_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
      .imm(imm), .carry_in(carry_in), .busy(busy), .done(done), .acc(acc),
      .data_out(data_out), .carry_out(carry_out), .cmp_flag(cmp_flag),
      .zero(zero), .parity(parity)
   );

   accum_alu_seq #(.W(16), .IMM_W(4)) dut16 (
      .clk(clk), .rst_n(rst16_n), .start(start16), .op(op16), .in_a(a16), .in_b(b16),
      .imm(imm16), .carry_in(ci16), .busy(busy16), .done(done16), .acc(acc16),
      .data_out(dout16), .carry_out(cout16), .cmp_flag(cmp16),
      .zero(zero16), .parity(par16)
   );

   int checks = 0;
   int passed = 0;

   logic [7:0] m_acc, m_dout;
   logic       m_cout;
   logic [1:0] m_cmp;

   logic [3:0] ops_tab [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
   endtask

   // Architectural effect of one operation and its start-to-done latency.
   task automatic model_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] im, input logic c, output int lat);
      int t;
      int n;
      lat = 2;
      n   = int'(b[2:0]);
      case (o)
         4'd0: m_acc = a & b;
         4'd1: m_acc = a | b;
         4'd2: begin t = int'(a) + int'(b) + int'(c);  m_acc = t[7:0]; m_cout = t[8]; end
         4'd3: begin t = int'(a) - int'(b) + int'(c);  m_acc = t[7:0]; m_cout = t[8]; end
         4'd4: begin t = int'(a) + int'(im) + int'(c); m_acc = t[7:0]; m_cout = t[8]; end
         4'd5: m_dout = a;
         4'd7: m_cmp = (a == b) ? 2'b10 : ((a > b) ? 2'b01 : 2'b00);
         4'd8: begin
            if (n == 0) begin
               m_acc = a; m_cout = 1'b0;
            end else begin
               t = (int'(a) << n) | (c ? ((1 << n) - 1) : 0);
               m_acc = t[7:0]; m_cout = a[8-n]; lat = n + 2;
            end
         end
         4'd9: begin
            if (n == 0) begin
               m_acc = a; m_cout = 1'b0;
            end else begin
               t = (int'(a) >> n) | (c ? (((1 << n) - 1) << (8 - n)) : 0);
               m_acc = t[7:0]; m_cout = a[n-1]; lat = n + 2;
            end
         end
         4'd10: begin
            t = int'(a) * int'(b);
            m_acc = t[7:0]; m_dout = t[15:8]; m_cout = |t[15:8]; lat = 10;
         end
         default: ;
      endcase
   endtask

   // Called just after a falling edge; returns just after the falling edge of the idle cycle.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] im, input logic c, input bit poke);
      int lat;
      int got;
      model_op(o, a, b, im, c, lat);
      op = o; in_a = a; in_b = b; imm = im; carry_in = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 0;
      for (int k = 1; k <= 16; k++) begin
         if (k == 1) check({tag, ".busy"}, 32'(busy), 32'd1);
         if (done === 1'b1) begin
            got = k;
            break;
         end
         start = poke && (k == 2);
         if (poke && (k == 2)) begin
            op = 4'd2; in_a = ~a; in_b = ~b;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, ".latency"}, 32'(got), 32'(lat));
      check({tag, ".acc"}, 32'(acc), 32'(m_acc));
      check({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
      check({tag, ".carry_out"}, 32'(carry_out), 32'(m_cout));
      check({tag, ".cmp_flag"}, 32'(cmp_flag), 32'(m_cmp));
      check({tag, ".zero"}, 32'(zero), 32'(m_acc == 8'd0));
      check({tag, ".parity"}, 32'(parity), 32'(^m_acc));
      @(negedge clk);
      check({tag, ".done_pulse"}, 32'(done), 32'd0);
      check({tag, ".idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic        saw_done;
      int          got;
      logic [3:0]  ro;
      logic [7:0]  ra, rb;
      logic [2:0]  ri;
      logic        rc;

      rst_n = 1'b0; start = 1'b0; op = 4'd0; in_a = 8'd0; in_b = 8'd0; imm = 3'd0; carry_in = 1'b0;
      rst16_n = 1'b0; start16 = 1'b0; op16 = 4'd0; a16 = 16'd0; b16 = 16'd0; imm16 = 4'd0; ci16 = 1'b0;
      repeat (2) @(negedge clk);

      check("reset.acc", 32'(acc), 32'd0);
      check("reset.data_out", 32'(data_out), 32'd0);
      check("reset.carry_out", 32'(carry_out), 32'd0);
      check("reset.cmp_flag", 32'(cmp_flag), 32'd0);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      check("reset.zero", 32'(zero), 32'd1);
      check("reset.parity", 32'(parity), 32'd0);
      check("reset16.acc", 32'(acc16), 32'd0);
      rst_n = 1'b1; rst16_n = 1'b1;
      m_acc = 8'd0; m_dout = 8'd0; m_cout = 1'b0; m_cmp = 2'b00;

      run_op("add_vec", 4'd2, 8'hF0, 8'h20, 3'd0, 1'b1, 1'b0);
      check("add_vec.const_acc", 32'(acc), 32'h11);
      run_op("shl_vec", 4'd8, 8'h81, 8'h03, 3'd0, 1'b1, 1'b0);
      check("shl_vec.const_acc", 32'(acc), 32'h0F);
      run_op("shr0_vec", 4'd9, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
      run_op("mul_vec", 4'd10, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b1);
      check("mul_vec.const_data_out", 32'(data_out), 32'hFE);
      run_op("cmp_eq", 4'd7, 8'd5, 8'd5, 3'd0, 1'b0, 1'b0);
      run_op("cmp_gt", 4'd7, 8'd9, 8'd3, 3'd0, 1'b0, 1'b0);
      run_op("cmp_lt", 4'd7, 8'd3, 8'd9, 3'd0, 1'b0, 1'b0);
      check("cmp.const_acc_kept", 32'(acc), 32'h01);
      run_op("sub_borrow", 4'd3, 8'h03, 8'h09, 3'd0, 1'b0, 1'b0);
      run_op("undef", 4'd12, 8'hAA, 8'h55, 3'd7, 1'b1, 1'b0);

      // Reset and start in the same cycle: reset wins.
      rst_n = 1'b0; start = 1'b1; op = 4'd2; in_a = 8'd1; in_b = 8'd1;
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      check("rst_start.busy", 32'(busy), 32'd0);
      check("rst_start.acc", 32'(acc), 32'd0);
      @(negedge clk);
      check("rst_start.not_issued", 32'(busy), 32'd0);
      m_acc = 8'd0; m_dout = 8'd0; m_cout = 1'b0; m_cmp = 2'b00;

      run_op("pre_mul", 4'd10, 8'hC3, 8'h5A, 3'd0, 1'b0, 1'b0);
      run_op("pre_cmp", 4'd7, 8'h70, 8'h10, 3'd0, 1'b0, 1'b0);

      // Reset during the fourth ITER cycle of a multiply.
      op = 4'd10; in_a = 8'hE7; in_b = 8'hB9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      saw_done = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (done === 1'b1) saw_done = 1'b1;
         if (k < 5) @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_mid.saw_done", 32'(saw_done), 32'd0);
      check("rst_mid.done", 32'(done), 32'd0);
      check("rst_mid.busy", 32'(busy), 32'd0);
      check("rst_mid.acc", 32'(acc), 32'd0);
      check("rst_mid.data_out", 32'(data_out), 32'd0);
      check("rst_mid.carry_out", 32'(carry_out), 32'd0);
      check("rst_mid.cmp_flag", 32'(cmp_flag), 32'd0);
      m_acc = 8'd0; m_dout = 8'd0; m_cout = 1'b0; m_cmp = 2'b00;
      run_op("add_after_rst", 4'd2, 8'h12, 8'h34, 3'd0, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ro = ops_tab[$urandom_range(0, 12)];
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         ri = 3'($urandom_range(0, 7));
         rc = 1'($urandom_range(0, 1));
         run_op("rnd", ro, ra, rb, ri, rc, 1'($urandom_range(0, 1)));
      end

      // Wide instance: ADDI with a zero-extended 4-bit immediate.
      op16 = 4'd4; a16 = 16'hFFFF; b16 = 16'h1234; imm16 = 4'hF; ci16 = 1'b0; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      got = 0;
      for (int k = 1; k <= 10; k++) begin
         if (done16 === 1'b1) begin
            got = k;
            break;
         end
         @(negedge clk);
      end
      check("addi16.latency", 32'(got), 32'd2);
      check("addi16.acc", 32'(acc16), 32'h000E);
      check("addi16.carry_out", 32'(cout16), 32'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/accum_alu_seq.md
ACCUM_ALU_SEQ -- requirements
Module: accum_alu_seq

Interface
REQ-001 Parameter: W, 8, datapath width (>=4, power of 2).
REQ-002 Parameter: IMM_W, 3, immediate width (1..W).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  one clock; reset is synchronous and active-low.
REQ-005 start  in  1  issue request; sampled only in IDLE.
REQ-006 op  in  4  opcode (alu_pkg::op_t).
REQ-007 in_a, in_b  in  W each  operands.
REQ-008 imm  in  IMM_W  unsigned immediate, zero-extended.
REQ-009 carry_in  in  1  carry/shift-fill input.
REQ-010 busy  out  1  high while not IDLE.
REQ-011 done  out  1  one-cycle pulse when results update.
REQ-012 acc  out  W  registered accumulator.
REQ-013 data_out  out  W  registered move / MUL high half.
REQ-014 carry_out  out  1  registered carry.
REQ-015 cmp_flag  out  2  registered: 10 A==B, 01 A>B, 00 A<B (unsigned).
REQ-016 zero, parity  out  1 each  combinational: ~|acc, ^acc.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC, ITER, DONE; start in IDLE SHALL capture op and operands into internal registers.
REQ-018 Single-cycle ops SHALL go IDLE->EXEC->DONE->IDLE; results and done appear 2 cycles after start.
REQ-019 AND/OR: acc = a&b / a|b; carry_out unchanged.
REQ-020 ADD: {carry_out,acc} = a+b+carry_in, W+1 bits; ADDI uses zero-extended imm instead of b.
REQ-021 SUB: {carry_out,acc} = a-b+carry_in in W+1 bits; carry_out = bit W (borrow).
REQ-022 MOV: data_out = a; acc, carry_out unchanged.
REQ-023 CMP: cmp_flag per REQ-015; acc, carry_out unchanged; only CMP writes cmp_flag.
REQ-024 SHL/SHR: amount n = b[log2(W)-1:0]; ITER SHALL shift one bit per cycle, fill = carry_in, carry_out = last bit shifted out; done n+2 cycles after start (n>=1).
REQ-025 SHL/SHR with n=0: acc = a, carry_out = 0, timing as single-cycle op.
REQ-026 MUL: unsigned shift-add, one multiplier bit per ITER cycle, W ITER cycles; {data_out,acc} = a*b; carry_out = |data_out; done W+2 cycles after start.
REQ-027 Undefined opcodes: no register changes except done pulse (single-cycle timing).
REQ-028 start while busy SHALL be ignored with no effect on the running operation.
REQ-029 ITER counter SHALL be log2(W)+1 bits and exit on reaching zero; no wrap.
REQ-030 DONE SHALL last exactly one cycle; start may be accepted the cycle after DONE (back-to-back).

Reset
REQ-031 rst_n low at a clk edge SHALL force IDLE and clear acc, data_out, carry_out, cmp_flag, busy, done, counters to 0.
REQ-032 Reset mid-ITER SHALL abort without done and leave outputs at reset values.
REQ-033 rst_n has priority over start in the same cycle.

Structure
REQ-034 alu_pkg SHALL hold op_t (AND=0,OR=1,ADD=2,SUB=3,ADDI=4,MOV=5,CMP=7,SHL=8,SHR=9,MUL=10) and state_t.
REQ-035 The iterative shift/multiply datapath SHALL be one sub-module, alu_iter_unit, parametrised by W.
REQ-036 Top level holds FSM, operand capture and result registers.

Verification
REQ-037 W=8: ADD a=0xF0,b=0x20,ci=1 -> acc=0x11, carry_out=1, done pulse 2 cycles after start.
REQ-038 W=8: SHL a=0x81,b=3,ci=1 -> acc=0x0F, carry_out=0, done at cycle 5; SHR a=0x01,b=0 -> acc=0x01, carry_out=0.
REQ-039 W=8: MUL a=0xFF,b=0xFF -> acc=0x01, data_out=0xFE, carry_out=1, done at cycle 10; start pulses mid-op ignored.
REQ-040 CMP (5,5)->10, (9,3)->01, (3,9)->00; acc unchanged across all three.
REQ-041 rst_n low in 4th ITER cycle of MUL -> no done, all outputs 0 next cycle; new ADD then completes normally.
REQ-042 W=16, IMM_W=4: ADDI a=0xFFFF, imm=0xF, ci=0 -> acc=0x000E, carry_out=1.
